// File: rtl/hmmm_core_param_if.sv
// Shared instruction/data memory port of the HMMM core: one req/ack transaction at a time.
// The core drives the request fields and holds them stable until the memory returns ack.
interface hmmm_core_param_if #(
  parameter int WIDTH = 8
);
  localparam int IW = WIDTH + 7;

  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_adr;
  logic [WIDTH-1:0] mem_wdata;
  logic [IW-1:0]    mem_rdata;
  logic             mem_ack;

  modport master (
    output mem_req, mem_we, mem_adr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_adr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/hmmm_core_param.sv
// Multi-cycle HMMM core (FETCH/EXEC/MEM/MUL/HALT): ALU and branch 2 cycles, load/store 3, mul 2+WIDTH.
// Memory backpressure is absorbed by holding FETCH/MEM, with outputs frozen, until mem_ack.
module hmmm_core_param #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic              ph1,
  input  logic              ph2,
  input  logic              reset,
  hmmm_core_param_if.master bus,
  output logic              halted
);
  localparam int IW = WIDTH + 7;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {FETCH, EXEC, MEM, MUL, HALT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc, pc_nxt, pc_inc;
  logic [IW-1:0]    ir;
  logic [WIDTH-1:0] regs [8];
  logic [WIDTH-1:0] mcand, mplier, acc, acc_sum;
  logic [CW-1:0]    mul_cnt;
  logic             mul_op, mul_last;
  logic             rf_we;
  logic [WIDTH-1:0] rf_wdata;
  logic [3:0]       funct;
  logic [2:0]       rd, rs1, rs2;
  logic [WIDTH-1:0] imm, rd_val, rs1_val, rs2_val;

  // All state is clocked on ph2; ph1 carries no logic in this implementation.
  logic unused_ph1;
  assign unused_ph1 = ph1;

  assign funct   = ir[IW-1 -: 4];
  assign rd      = ir[IW-5 -: 3];
  assign imm     = ir[WIDTH-1:0];
  assign rs1     = imm[WIDTH-1 -: 3];
  assign rs2     = imm[WIDTH-4 -: 3];
  assign rd_val  = regs[rd];
  assign rs1_val = regs[rs1];
  assign rs2_val = regs[rs2];
  assign pc_inc  = pc + WIDTH'(1);

  assign mul_op   = MUL_EN && (funct == 4'b0011);
  assign mul_last = (mul_cnt == CW'(WIDTH - 1));
  assign acc_sum  = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge ph2) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: if (bus.mem_ack) state_nxt = EXEC;
      EXEC: begin
        if (funct == 4'b0001 || funct == 4'b0010) state_nxt = MEM;
        else if (mul_op)                          state_nxt = MUL;
        else if (funct == 4'b1111)                state_nxt = HALT;
        else                                      state_nxt = FETCH;
      end
      MEM:     if (bus.mem_ack) state_nxt = FETCH;
      MUL:     if (mul_last) state_nxt = FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  // Reset gates the bus so an abandoned transaction disappears in the reset cycle itself.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_adr   = '0;
    bus.mem_wdata = '0;
    halted        = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          bus.mem_req = 1'b1;
          bus.mem_adr = pc;
        end
        MEM: begin
          bus.mem_req   = 1'b1;
          bus.mem_we    = (funct == 4'b0010);
          bus.mem_adr   = rs2_val;
          bus.mem_wdata = rd_val;
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = '0;
    pc_nxt   = pc;
    case (state)
      EXEC: begin
        pc_nxt = pc_inc;
        case (funct)
          4'b0000: begin rf_we = 1'b1; rf_wdata = imm;               end
          4'b0100: begin rf_we = 1'b1; rf_wdata = rs2_val;           end
          4'b0101: begin rf_we = 1'b1; rf_wdata = '0 - rs2_val;      end
          4'b0110: begin rf_we = 1'b1; rf_wdata = rs1_val + rs2_val; end
          4'b0111: begin rf_we = 1'b1; rf_wdata = rs1_val - rs2_val; end
          4'b1000: if (rd_val == '0) pc_nxt = imm;
          4'b1001: if (rd_val != '0) pc_nxt = imm;
          4'b1010: if (!rd_val[WIDTH-1] && rd_val != '0) pc_nxt = imm;
          4'b1011: if (rd_val[WIDTH-1]) pc_nxt = imm;
          4'b1100: pc_nxt = imm;
          4'b1110: pc_nxt = rd_val;
          4'b0001, 4'b0010, 4'b1111: pc_nxt = pc;
          4'b0011: if (MUL_EN) pc_nxt = pc;
          default: ;
        endcase
      end
      MEM: begin
        if (bus.mem_ack) begin
          pc_nxt = pc_inc;
          if (funct == 4'b0001) begin
            rf_we    = 1'b1;
            rf_wdata = bus.mem_rdata[WIDTH-1:0];
          end
        end
      end
      MUL: begin
        if (mul_last) begin
          rf_we    = 1'b1;
          rf_wdata = acc_sum;
          pc_nxt   = pc_inc;
        end
      end
      default: ;
    endcase
  end

  // Operands are captured at EXEC, so rd may alias rs1/rs2 for mul.
  always_ff @(posedge ph2) begin
    if (reset) begin
      pc      <= '0;
      ir      <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      mul_cnt <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      pc <= pc_nxt;
      if (state == FETCH && bus.mem_ack) ir <= bus.mem_rdata;
      if (rf_we) regs[rd] <= rf_wdata;
      if (state == EXEC && mul_op) begin
        mcand   <= rs1_val;
        mplier  <= rs2_val;
        acc     <= '0;
        mul_cnt <= '0;
      end else if (state == MUL) begin
        acc     <= acc_sum;
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        mul_cnt <= mul_cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_hmmm_core_param.sv
// Directed programs for an 8-bit core (mul enabled) and a 12-bit core (mul disabled).
// Stores are checked against a queue of expected {address, data} pairs filled when each program is loaded.
module tb_hmmm_core_param;
  logic ph1, ph2, reset8, reset12, halted8, halted12;
  int   n_chk, n_fail, wait8, wcnt8, c;

  logic [14:0] mem8  [256];
  logic [18:0] mem12 [4096];
  logic [15:0] sb8  [$];
  logic [23:0] sb12 [$];
  logic [7:0]  h_adr, h_wd;
  logic        h_we;

  hmmm_core_param_if #(.WIDTH(8))  b8 ();
  hmmm_core_param_if #(.WIDTH(12)) b12 ();

  hmmm_core_param #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
    .ph1(ph1), .ph2(ph2), .reset(reset8), .bus(b8), .halted(halted8));
  hmmm_core_param #(.WIDTH(12), .MUL_EN(1'b0)) dut12 (
    .ph1(ph1), .ph2(ph2), .reset(reset12), .bus(b12), .halted(halted12));

  initial begin
    ph1 = 1'b0; ph2 = 1'b0;
    forever begin
      #1 ph1 = 1'b1; #8 ph1 = 1'b0;
      #1 ph2 = 1'b1; #8 ph2 = 1'b0; #2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] i8(input logic [3:0] f, input logic [2:0] rd, input logic [7:0] p);
    return {f, rd, p};
  endfunction
  function automatic logic [7:0] r8(input logic [2:0] s1, input logic [2:0] s2);
    return {s1, s2, 2'b00};
  endfunction
  function automatic logic [18:0] i12(input logic [3:0] f, input logic [2:0] rd, input logic [11:0] p);
    return {f, rd, p};
  endfunction
  function automatic logic [11:0] r12(input logic [2:0] s1, input logic [2:0] s2);
    return {s1, s2, 6'b000000};
  endfunction

  // 8-bit memory: programmable wait states, handshake stability and store checks.
  always @(negedge ph2) begin
    if (b8.mem_req) begin
      if (wcnt8 == 0) begin
        h_adr = b8.mem_adr; h_we = b8.mem_we; h_wd = b8.mem_wdata;
      end else begin
        chk("hold8", {15'd0, b8.mem_adr, b8.mem_we, b8.mem_wdata}, {15'd0, h_adr, h_we, h_wd});
      end
      if (wcnt8 >= wait8) begin
        b8.mem_ack   = 1'b1;
        b8.mem_rdata = mem8[b8.mem_adr];
        if (b8.mem_we) begin
          chk("store8", {16'd0, b8.mem_adr, b8.mem_wdata},
              (sb8.size() > 0) ? {16'd0, sb8.pop_front()} : 'x);
          mem8[b8.mem_adr] = {7'd0, b8.mem_wdata};
        end
        wcnt8 = 0;
      end else begin
        b8.mem_ack = 1'b0;
        wcnt8++;
      end
    end else begin
      b8.mem_ack = 1'b0;
      wcnt8 = 0;
    end
  end

  // 12-bit memory: zero wait states.
  always @(negedge ph2) begin
    b12.mem_ack = b12.mem_req;
    if (b12.mem_req) begin
      b12.mem_rdata = mem12[b12.mem_adr];
      if (b12.mem_we) begin
        chk("store12", {8'd0, b12.mem_adr, b12.mem_wdata},
            (sb12.size() > 0) ? {8'd0, sb12.pop_front()} : 'x);
        mem12[b12.mem_adr] = {7'd0, b12.mem_wdata};
      end
    end
  end

  task automatic step();
    @(posedge ph2);
    #1;
  endtask

  task automatic begin_reset8(input int waits);
    reset8 = 1'b1;
    wait8  = 0;
    sb8.delete();
    for (int i = 0; i < 256; i++) mem8[i] = '0;
    wait8 = waits;
  endtask

  task automatic end_reset8();
    step();
    chk("reset8_outputs", {12'd0, b8.mem_req, b8.mem_we, b8.mem_adr, b8.mem_wdata, halted8}, 32'd0);
    reset8 = 1'b0;
  endtask

  task automatic run(input string tag, input bit w12, input int exp);
    int n = 0;
    while ((w12 ? halted12 : halted8) !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_cycles"}, n, exp);
    for (int i = 0; i < 3; i++) begin
      step();
      chk({tag, "_noreq"}, w12 ? b12.mem_req : b8.mem_req, 32'd0);
    end
    chk({tag, "_sb"}, w12 ? sb12.size() : sb8.size(), 32'd0);
  endtask

  task automatic load_a(input bit stores);
    mem8[0] = i8(4'h0, 3'd1, 8'd5);
    mem8[1] = i8(4'h0, 3'd2, 8'd3);
    mem8[2] = i8(4'h6, 3'd3, r8(3'd1, 3'd2));
    mem8[3] = i8(4'h7, 3'd4, r8(3'd2, 3'd1));
    if (stores) begin
      mem8[4] = i8(4'h0, 3'd7, 8'h80);
      mem8[5] = i8(4'h2, 3'd3, r8(3'd0, 3'd7));
      mem8[6] = i8(4'h0, 3'd6, 8'h81);
      mem8[7] = i8(4'h2, 3'd4, r8(3'd0, 3'd6));
      mem8[8] = i8(4'hF, 3'd0, 8'h00);
    end else begin
      mem8[4] = i8(4'hF, 3'd0, 8'h00);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; wait8 = 0; wcnt8 = 0;
    reset8 = 1'b1; reset12 = 1'b1;
    b8.mem_ack = 1'b0;  b8.mem_rdata = '0;
    b12.mem_ack = 1'b0; b12.mem_rdata = '0;
    for (int i = 0; i < 4096; i++) mem12[i] = '0;

    // Base ALU program, zero waits and two waits per transaction.
    begin_reset8(0); load_a(1'b0); end_reset8();
    run("prog_a", 1'b0, 10);
    begin_reset8(2); load_a(1'b0); end_reset8();
    run("prog_a_wait2", 1'b0, 20);

    // Same arithmetic with results stored: 3+5=8, 3-5=0xFE.
    begin_reset8(2); load_a(1'b1);
    sb8.push_back(16'h8008); sb8.push_back(16'h81FE);
    end_reset8();
    run("prog_a_store", 1'b0, 42);

    // Store then load back through memory, one wait per transaction.
    begin_reset8(1);
    mem8[0] = i8(4'h0, 3'd1, 8'h40);
    mem8[1] = i8(4'h0, 3'd2, 8'hA5);
    mem8[2] = i8(4'h2, 3'd2, r8(3'd0, 3'd1));
    mem8[3] = i8(4'h1, 3'd5, r8(3'd0, 3'd1));
    mem8[4] = i8(4'h0, 3'd7, 8'h81);
    mem8[5] = i8(4'h2, 3'd5, r8(3'd0, 3'd7));
    mem8[6] = i8(4'hF, 3'd0, 8'h00);
    sb8.push_back(16'h40A5); sb8.push_back(16'h81A5);
    end_reset8();
    run("ldst", 1'b0, 27);

    // Multiply: 13*11=143, then 20*20 mod 256 = 0x90 with rd aliasing rs1.
    begin_reset8(0);
    mem8[0]  = i8(4'h0, 3'd1, 8'd13);
    mem8[1]  = i8(4'h0, 3'd2, 8'd11);
    mem8[2]  = i8(4'h3, 3'd3, r8(3'd1, 3'd2));
    mem8[3]  = i8(4'h0, 3'd7, 8'h80);
    mem8[4]  = i8(4'h2, 3'd3, r8(3'd0, 3'd7));
    mem8[5]  = i8(4'h0, 3'd1, 8'd20);
    mem8[6]  = i8(4'h0, 3'd2, 8'd20);
    mem8[7]  = i8(4'h3, 3'd1, r8(3'd1, 3'd2));
    mem8[8]  = i8(4'h0, 3'd6, 8'h81);
    mem8[9]  = i8(4'h2, 3'd1, r8(3'd0, 3'd6));
    mem8[10] = i8(4'hF, 3'd0, 8'h00);
    sb8.push_back(16'h808F); sb8.push_back(16'h8190);
    end_reset8();
    run("mul", 1'b0, 40);

    // Branches on a negative value, jumpr to 0xFF and PC wrap back to 0.
    begin_reset8(0);
    mem8[0]   = i8(4'h9, 3'd5, 8'd20);
    mem8[1]   = i8(4'h0, 3'd1, 8'h80);
    mem8[2]   = i8(4'h0, 3'd7, 8'h90);
    mem8[3]   = i8(4'hB, 3'd1, 8'd6);
    mem8[4]   = i8(4'h2, 3'd1, r8(3'd0, 3'd7));
    mem8[5]   = i8(4'hF, 3'd0, 8'h00);
    mem8[6]   = i8(4'hA, 3'd1, 8'd4);
    mem8[7]   = i8(4'h0, 3'd2, 8'h5A);
    mem8[8]   = i8(4'h2, 3'd2, r8(3'd0, 3'd7));
    mem8[9]   = i8(4'h0, 3'd5, 8'h77);
    mem8[10]  = i8(4'h0, 3'd6, 8'hFF);
    mem8[11]  = i8(4'hE, 3'd6, 8'h00);
    mem8[255] = i8(4'hD, 3'd0, 8'h00);
    mem8[20]  = i8(4'h0, 3'd4, 8'h91);
    mem8[21]  = i8(4'h2, 3'd5, r8(3'd0, 3'd4));
    mem8[22]  = i8(4'h8, 3'd3, 8'd24);
    mem8[23]  = i8(4'h2, 3'd1, r8(3'd0, 3'd7));
    mem8[24]  = i8(4'hC, 3'd0, 8'd26);
    mem8[25]  = i8(4'h2, 3'd1, r8(3'd0, 3'd7));
    mem8[26]  = i8(4'hF, 3'd0, 8'h00);
    sb8.push_back(16'h905A); sb8.push_back(16'h9177);
    end_reset8();
    run("branch", 1'b0, 36);

    // Reset while a load is stalled in MEM waiting for ack.
    begin_reset8(0);
    mem8[0]    = i8(4'h0, 3'd1, 8'h40);
    mem8[1]    = i8(4'h1, 3'd2, r8(3'd0, 3'd1));
    mem8[2]    = i8(4'h0, 3'd7, 8'h80);
    mem8[3]    = i8(4'h2, 3'd2, r8(3'd0, 3'd7));
    mem8[4]    = i8(4'hF, 3'd0, 8'h00);
    mem8[8'h40] = 15'h0099;
    end_reset8();
    c = 0;
    do begin
      step();
      c++;
    end while (!(b8.mem_req === 1'b1 && b8.mem_adr === 8'h40) && c < 50);
    chk("reach_mem", c, 32'd4);
    wait8 = 255;
    step(); step();
    chk("mem_withheld", {22'd0, b8.mem_req, b8.mem_we, b8.mem_adr}, {22'd0, 1'b1, 1'b0, 8'h40});
    reset8 = 1'b1;
    #1;
    chk("reset_drops_req", b8.mem_req, 32'd0);
    step();
    reset8 = 1'b0;
    wait8  = 0;
    #1;
    chk("refetch_at_0", {22'd0, b8.mem_req, b8.mem_we, b8.mem_adr}, {22'd0, 1'b1, 1'b0, 8'h00});
    sb8.push_back(16'h8099);
    run("reset_mid_mem", 1'b0, 12);

    // 12-bit core: carry dropped at bit 12, and 0011 is a 2-cycle nop with MUL_EN=0.
    reset8 = 1'b1;
    mem12[0] = i12(4'h0, 3'd1, 12'hFFF);
    mem12[1] = i12(4'h6, 3'd1, r12(3'd1, 3'd1));
    mem12[2] = i12(4'h0, 3'd3, 12'h123);
    mem12[3] = i12(4'h3, 3'd3, r12(3'd1, 3'd1));
    mem12[4] = i12(4'h0, 3'd7, 12'h100);
    mem12[5] = i12(4'h2, 3'd1, r12(3'd0, 3'd7));
    mem12[6] = i12(4'h0, 3'd6, 12'h101);
    mem12[7] = i12(4'h2, 3'd3, r12(3'd0, 3'd6));
    mem12[8] = i12(4'hF, 3'd0, 12'h000);
    sb12.push_back(24'h100FFE); sb12.push_back(24'h101123);
    step();
    chk("reset12_outputs", {6'd0, b12.mem_req, b12.mem_we, b12.mem_adr, b12.mem_wdata, halted12}, 32'd0);
    reset12 = 1'b0;
    run("w12", 1'b1, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
